// File: rtl/phy_rx_pkg.sv
// Shared types and helpers for the PHY receive lane aligner.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SYNCING = 2'd1,
    SYNCED  = 2'd2
  } state_e;

  localparam logic [7:0] PHY_RX_COMMA_DEFAULT = 8'hBC;

  // Lane pointer needs at least one bit even for a single lane.
  function automatic int unsigned lane_ptr_w(input int unsigned lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/phy_rx_comma_det.sv
// Serial-to-parallel shifter (LSB first) with comma comparator.
module phy_rx_comma_det
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = PHY_RX_COMMA_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  output logic [7:0] sr_o,
  output logic       is_comma_o
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;

  assign sr_d = {data_i, sr_q[7:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o       = sr_q;
  assign is_comma_o = (sr_q == COMMA);

endmodule

// File: rtl/phy_rx_lane_align.sv
// Comma-aligned serial receiver striping bytes across LANES byte lanes.
// Optional loss-of-sync detection: define PHY_RX_LOSS_DET_EN.
module phy_rx_lane_align
  import phy_rx_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter logic [7:0]  COMMA      = PHY_RX_COMMA_DEFAULT,
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2
) (
  input  logic               clk_32f,
  input  logic               reset,
  input  logic               data_in,
  output logic [LANES*8-1:0] data_rx,
  output logic [LANES-1:0]   valid_rx,
  output logic               active,
  output logic [1:0]         state
);

  localparam int unsigned   PW        = lane_ptr_w(LANES);
  localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);
  localparam logic [3:0]    SYNC_CNT4 = SYNC_COUNT[3:0];

  logic [7:0]         sr;
  logic               is_comma;
  logic               boundary;
  logic [3:0]         comma_inc;

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         comma_cnt_q, comma_cnt_d;
  logic [PW-1:0]      lane_ptr_q, lane_ptr_d;
  logic [LANES*8-1:0] data_q, data_d;
  logic [LANES-1:0]   valid_q, valid_d;

`ifdef PHY_RX_LOSS_DET_EN
  localparam logic [3:0] LOSS_CNT4 = LOSS_COUNT[3:0];
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic [3:0] miss_inc;
  assign miss_inc = (miss_cnt_q == 4'hF) ? 4'hF : miss_cnt_q + 4'd1;
`endif

  phy_rx_comma_det #(
    .COMMA (COMMA)
  ) u_comma_det (
    .clk_i      (clk_32f),
    .rst_i      (reset),
    .data_i     (data_in),
    .sr_o       (sr),
    .is_comma_o (is_comma)
  );

  assign boundary  = (bit_cnt_q == 3'd0);
  assign comma_inc = (comma_cnt_q == 4'hF) ? 4'hF : comma_cnt_q + 4'd1;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      lane_ptr_q  <= '0;
      data_q      <= '0;
      valid_q     <= '0;
`ifdef PHY_RX_LOSS_DET_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      lane_ptr_q  <= lane_ptr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
`ifdef PHY_RX_LOSS_DET_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    lane_ptr_d  = lane_ptr_q;
    data_d      = data_q;
    valid_d     = '0;
`ifdef PHY_RX_LOSS_DET_EN
    miss_cnt_d  = miss_cnt_q;
`endif

    case (state_q)
      SEARCH: begin
        // Restarting bit_cnt at 1 puts the next boundary 8 cycles after the match.
        if (is_comma) begin
          bit_cnt_d   = 3'd1;
          comma_cnt_d = 4'd1;
          lane_ptr_d  = '0;
          state_d     = (SYNC_COUNT == 1) ? SYNCED : SYNCING;
        end
      end

      SYNCING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc >= SYNC_CNT4) begin
              state_d    = SYNCED;
              lane_ptr_d = '0;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end

      SYNCED: begin
        if (boundary) begin
          if (is_comma) begin
            lane_ptr_d = '0;
`ifdef PHY_RX_LOSS_DET_EN
            miss_cnt_d = '0;
`endif
          end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
              if (lane_ptr_q == PW'(i)) begin
                data_d[i*8 +: 8] = sr;
                valid_d[i]       = 1'b1;
              end
            end
            lane_ptr_d = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + 1'b1;
          end
        end
`ifdef PHY_RX_LOSS_DET_EN
        else if (is_comma) begin
          if (miss_inc >= LOSS_CNT4) begin
            state_d     = SEARCH;
            lane_ptr_d  = '0;
            comma_cnt_d = '0;
            miss_cnt_d  = '0;
            valid_d     = '0;
            data_d      = data_q;
          end else begin
            miss_cnt_d = miss_inc;
          end
        end
`endif
      end

      default: begin
        state_d     = SEARCH;
        comma_cnt_d = '0;
        lane_ptr_d  = '0;
      end
    endcase
  end

  assign data_rx  = data_q;
  assign valid_rx = valid_q;
  assign active   = (state_q == SYNCED);
  assign state    = state_q;

endmodule

// File: tb/tb_phy_rx_lane_align.sv
// Scoreboard bench: a bit-stream reference model predicts lane strobes and sync state.
module tb_phy_rx_lane_align;

  localparam int         LANES = 4;
  localparam int         SC    = 4;
  localparam int         LC    = 2;
  localparam logic [7:0] CM    = 8'hBC;
`ifdef PHY_RX_LOSS_DET_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic               clk = 1'b1;
  logic               reset = 1'b1;
  logic               data_in = 1'b0;
  logic [LANES*8-1:0] data_rx;
  logic [LANES-1:0]   valid_rx;
  logic               active;
  logic [1:0]         state;

  phy_rx_lane_align #(
    .LANES      (LANES),
    .COMMA      (CM),
    .SYNC_COUNT (SC),
    .LOSS_COUNT (LC)
  ) dut (
    .clk_32f  (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_rx  (data_rx),
    .valid_rx (valid_rx),
    .active   (active),
    .state    (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobes = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [LANES*8-1:0] data;
    logic [LANES-1:0]   valid;
    int                 at;
  } exp_t;
  exp_t sbq[$];

  // Reference model: works on the stream of bits received since reset.
  bit                 hist[$];
  int                 m_mode, m_cnt, m_phase, m_lane, m_miss;
  logic [LANES*8-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sbq.delete();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_lane = 0; m_miss = 0;
    m_data = '0;
  endtask

  task automatic model_step(input bit b);
    logic [7:0] w;
    int         j;
    bit         on_bound;
    exp_t       e;
    hist.push_back(b);
    w = '0;
    for (int i = 0; i < 8; i++)
      if (hist.size() > i) w[7-i] = hist[hist.size()-1-i];
    j = hist.size() - 1;
    on_bound = (((j - m_phase) % 8) == 0);
    case (m_mode)
      0: if (w == CM) begin
           m_cnt = 1; m_phase = j; m_lane = 0;
           m_mode = (SC == 1) ? 2 : 1;
         end
      1: if (on_bound) begin
           if (w == CM) begin
             m_cnt++;
             if (m_cnt >= SC) begin m_mode = 2; m_lane = 0; end
           end else begin
             m_mode = 0; m_cnt = 0;
           end
         end
      default: begin
        if (on_bound) begin
          if (w == CM) begin
            m_lane = 0; m_miss = 0;
          end else begin
            m_data[m_lane*8 +: 8] = w;
            e.data  = m_data;
            e.valid = LANES'(1) << m_lane;
            e.at    = cyc + 1;
            sbq.push_back(e);
            m_lane = (m_lane + 1) % LANES;
          end
        end else if (LOSS_EN && w == CM) begin
          m_miss++;
          if (m_miss >= LC) begin
            m_mode = 0; m_lane = 0; m_cnt = 0; m_miss = 0;
          end
        end
      end
    endcase
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    #1;
    chk("state", 64'(state), 64'(m_mode));
    chk("active", 64'(active), 64'(m_mode == 2));
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(CM);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_data", 64'(data_rx), 64'd0);
    chk("rst_valid", 64'(valid_rx), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_rx !== '0) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got valid=%b data=%h expected none", valid_rx, data_rx);
      end else begin
        e = sbq.pop_front();
        strobes++;
        chk("strobe_valid", 64'(valid_rx), 64'(e.valid));
        chk("strobe_data", 64'(data_rx), 64'(e.data));
        chk("strobe_cycle", 64'(cyc), 64'(e.at));
      end
    end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      total++; bad++;
      $display("FAIL missing_strobe: got none expected valid=%b data=%h", e.valid, e.data);
    end
  end

  initial begin
    model_reset();
    #100;
    chk("init_data", 64'(data_rx), 64'd0);
    chk("init_valid", 64'(valid_rx), 64'd0);
    chk("init_active", 64'(active), 64'd0);
    chk("init_state", 64'(state), 64'd0);
    #45;
    reset = 1'b0;

    // Commas, eight data bytes, then an idle comma restarting lane 0.
    strobes = 0;
    send_commas(15);
    chk("active_after_commas", 64'(active), 64'd1);
    send_byte(8'hFF); send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hCC);
    send_byte(8'hBB); send_byte(8'h99); send_byte(8'hAA); send_byte(8'h88);
    send_byte(CM); send_byte(8'h77);
    send_commas(3);
    chk("lanes_after_77", 64'(data_rx), 64'h88AA9977);
    chk("strobe_count", 64'(strobes), 64'd9);

    // Sync attempt broken by a data byte, then a clean one.
    mid_reset();
    send_commas(3); send_byte(8'h55);
    chk("active_after_break", 64'(active), 64'd0);
    send_commas(5);
    chk("active_after_resync", 64'(active), 64'd1);
    send_byte(8'h12); send_byte(8'h34); send_commas(2);

    // Alignment at a non-zero bit offset.
    mid_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_commas(6);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(CM);
    chk("offset_lanes", 64'(data_rx), 64'h44332211);

    // One slipped bit while synced.
    send_byte(8'h5A);
    send_bit(1'b0);
    send_commas(3);
    chk("active_after_slip", 64'(active), LOSS_EN ? 64'd0 : 64'd1);
    send_commas(5);
    chk("active_after_slip_resync", 64'(active), 64'd1);
    send_byte(8'h66); send_byte(8'h67); send_commas(2);

    // Reset in the middle of a data byte, then data with no commas.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    mid_reset();
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h0F);
    chk("no_sync_after_reset", 64'(active), 64'd0);
    send_commas(5);
    send_byte(8'hC3); send_byte(8'h3C); send_commas(2);

    // Randomised stream: commas, data bytes and stray bits.
    mid_reset();
    send_commas(5);
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) send_byte(CM);
      else if (r == 3) begin
        int k;
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
      end else send_byte(8'($urandom_range(0, 255)));
    end
    send_commas(3);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane_align.md
# phy_rx_lane_align

Parametrised PHY receive front end. It takes the serial line on the bit clock, finds byte alignment from a repeated comma character, and declares sync after a programmable number of aligned commas. Once in sync, it stripes the non-comma bytes round-robin across `LANES` byte lanes, each with a one-cycle valid strobe. It sits between the serial line input and the per-lane receive logic, and generalises the fixed four-lane receiver with configurable lanes, comma, sync threshold and optional loss-of-sync.

## Interface
- `LANES`, 4: number of output byte lanes, 1..8.
- `COMMA`, 8'hBC: alignment/idle character.
- `SYNC_COUNT`, 4: consecutive aligned commas required for sync, 1..15.
- `LOSS_COUNT`, 2: misaligned commas that drop sync, 1..15. Used only with loss detection.

- `clk_32f` input, 1: bit clock; one serial bit per rising edge.
- `reset` input, 1: asynchronous, active-high.
- `data_in` input, 1: serial line, LSB of each byte first.
- `data_rx` output, LANES*8: lane i is `[8i+7:8i]`, holds its last byte.
- `valid_rx` output, LANES: per-lane one-cycle strobe, asserted when that lane is updated.
- `active` output, 1: high while in SYNCED.
- `state` output, 2: FSM state (debug).

## Operation
- Shift register: `sr <= {data_in, sr[7:1]}` every edge. `sr` holds the most recent 8 bits.
- `bit_cnt` is 3 bits, free-running mod 8. A byte boundary is any cycle with `bit_cnt==0` outside SEARCH.
- States:
  - SEARCH (0): on any cycle with `sr==COMMA`, set `bit_cnt<=1` and `comma_cnt<=1`. Go to SYNCING, or go directly to SYNCED if SYNC_COUNT==1.
  - SYNCING (1): at each boundary:
    - comma: `comma_cnt++`. When it reaches SYNC_COUNT, go to SYNCED.
    - non-comma: go to SEARCH and clear `comma_cnt`.
    - Non-boundary cycles are ignored.
  - SYNCED (2): at each boundary:
    - comma: idle. No strobe; `lane_ptr<=0`.
    - non-comma: `data_rx[lane_ptr]<=sr` and `valid_rx[lane_ptr]<=1`. `lane_ptr` increments and wraps from LANES-1 to 0.
- `lane_ptr` is 0 on entry to SYNCED. It has width max(1, clog2(LANES)).
- `comma_cnt` saturates and never wraps.
- State 3 is unused. Any entry to it returns to SEARCH.

## Timing
- Reset values: `data_rx=0`, `valid_rx=0`, `active=0`, `state=SEARCH`. Internals: `sr=0`, `bit_cnt=0`, `comma_cnt=0`, `lane_ptr=0`, `miss_cnt=0`. Reset asserted mid-operation clears everything immediately; sync must then be reacquired.
- Comma match in cycle c: the next boundary is cycle c+8.
- Output latency: a byte completed in boundary cycle c appears on `data_rx`/`valid_rx` after the edge ending cycle c. At most one lane strobes per 8 cycles.
- `valid_rx` deasserts at the next edge; `data_rx` holds.
- `active` rises at the edge that enters SYNCED and falls at the edge that leaves it. No strobe is issued on the entry edge.
- A non-comma byte in SYNCED never returns the block to SYNCING.

## Configuration
- Macro `PHY_RX_LOSS_DET_EN`.
- Defined:
  - In SYNCED, a cycle with `sr==COMMA` and `bit_cnt!=0` increments `miss_cnt`.
  - An aligned comma clears `miss_cnt`.
  - When `miss_cnt` reaches LOSS_COUNT: go to SEARCH at that edge, drop `active`, clear `lane_ptr`, `comma_cnt` and `miss_cnt`. Any byte completing that cycle is discarded.
- Undefined: SYNCED is sticky until `reset`, and `miss_cnt` is not built.

## Structure
- Package `phy_rx_pkg`:
  - state enum SEARCH/SYNCING/SYNCED.
  - `PHY_RX_COMMA_DEFAULT=8'hBC`.
  - lane-pointer width function.
- Sub-module `phy_rx_comma_det`: the 8-bit shift register and `COMMA` comparator, outputting `sr` and `is_comma`.
- The top level holds `bit_cnt`, the FSM, the counters and the lane registers.

## Test plan
- Reset held for 145 time units, then 15×0xBC, then FF DD EE CC BB 99 AA 88 (LANES=4) -> `active` high after the 4th aligned comma. Lanes 0..3 = FF,DD,EE,CC, then BB,99,AA,88. 8 strobes, exactly 8 cycles apart.
- After that data, BC then 77 -> no strobe for BC. 77 lands on lane 0. The trailing commas produce no strobes.
- SYNC_COUNT=4 with 3 commas then 0x55 -> returns to SEARCH and `active` stays 0. Four further commas -> SYNCED.
- Stream starting with 3 random bits before the commas -> alignment found at the bit offset. Data bytes are still recovered intact.
- With `PHY_RX_LOSS_DET_EN`, in SYNCED, insert 1 extra bit, then commas -> 2nd misaligned comma drops `active`. Resync follows after SYNC_COUNT commas. Without the macro, `active` stays 1.
- Assert `reset` mid-data-byte -> all outputs are 0 at once. Resync is required before any strobe.
